// File: rtl/fleet_status_tracker_if.sv
// Fleet tracker bundle: sample strobe, restart, hit-matrix rows, sink-event handshake and
// status decodes; the game controller is master, the tracker is slave.
interface fleet_status_tracker_if #(
  parameter int unsigned NUM_BOATS  = 5,
  parameter int unsigned BOAT_CELLS = 5
);
  localparam int unsigned CW = $clog2(NUM_BOATS + 1);
  localparam int unsigned IW = (NUM_BOATS > 1) ? $clog2(NUM_BOATS) : 1;

  logic                  enable;
  logic                  clear;
  logic [BOAT_CELLS-1:0] barcos [NUM_BOATS-1:0];
  logic                  evt_ack;
  logic [NUM_BOATS-1:0]  alive;
  logic [CW-1:0]         sunk_count;
  logic                  all_sunk;
  logic                  evt_valid;
  logic [IW-1:0]         evt_id;
  logic                  armed;

  modport master (
    output enable, clear, barcos, evt_ack,
    input  alive, sunk_count, all_sunk, evt_valid, evt_id, armed
  );

  modport slave (
    input  enable, clear, barcos, evt_ack,
    output alive, sunk_count, all_sunk, evt_valid, evt_id, armed
  );
endinterface

// File: rtl/fleet_status_tracker.sv
// Battleship fleet tracker: alive mask, sunk count, game-over and queued sink events.
// Define FLEET_STICKY_SUNK_EN to make a sunk boat stay sunk for the rest of the game.
module fleet_status_tracker #(
  parameter int unsigned NUM_BOATS  = 5,
  parameter int unsigned BOAT_CELLS = 5
) (
  input logic                   clk,
  input logic                   rst,
  fleet_status_tracker_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_BOATS + 1);
  localparam int unsigned IW = (NUM_BOATS > 1) ? $clog2(NUM_BOATS) : 1;

  typedef enum logic [1:0] {StIdle, StTrack, StOver} state_e;

  state_e               state_q, state_d;
  logic [NUM_BOATS-1:0] alive_q, alive_d;
  logic [NUM_BOATS-1:0] pending_q, pending_d;
  logic [NUM_BOATS-1:0] row_nz;
  logic [NUM_BOATS-1:0] newly;
  logic [IW-1:0]        id;
  logic [CW-1:0]        cnt;

  always_comb begin
    row_nz = '0;
    for (int j = 0; j < NUM_BOATS; j++) begin
      row_nz[j] = |bus.barcos[j];
    end
    newly = alive_q & ~row_nz;
  end

  // Lowest pending index wins.
  always_comb begin
    id = '0;
    for (int j = NUM_BOATS - 1; j >= 0; j--) begin
      if (pending_q[j]) id = IW'(j);
    end
  end

  always_comb begin
    cnt = '0;
    for (int j = 0; j < NUM_BOATS; j++) begin
      cnt = cnt + CW'(!alive_q[j]);
    end
  end

  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    pending_d = pending_q;
    if (|pending_q && bus.evt_ack) pending_d[id] = 1'b0;

    unique case (state_q)
      StIdle: begin
        alive_d   = '0;
        pending_d = '0;
        if (bus.enable) begin
          alive_d = row_nz;
          state_d = (row_nz == '0) ? StOver : StTrack;
        end
      end
      StTrack: begin
        if (bus.enable) begin
          // OR after the ack clear so a coincident sink keeps its bit pending.
          pending_d = pending_d | newly;
`ifdef FLEET_STICKY_SUNK_EN
          alive_d = alive_q & row_nz;
`else
          alive_d = row_nz;
`endif
          if (alive_d == '0) state_d = StOver;
        end
      end
      StOver: ;
      default: state_d = StIdle;
    endcase

    if (bus.clear) begin
      state_d   = StIdle;
      alive_d   = '0;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      alive_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      pending_q <= pending_d;
    end
  end

  assign bus.alive      = alive_q;
  assign bus.sunk_count = (state_q == StIdle) ? '0 : cnt;
  assign bus.all_sunk   = (state_q == StOver);
  assign bus.armed      = (state_q != StIdle);
  assign bus.evt_valid  = |pending_q;
  assign bus.evt_id     = id;
endmodule

// File: tb/tb_fleet_status_tracker.sv
// Directed bench for fleet_status_tracker: stimulus queues expected sink events, an
// auto-acking monitor pops and compares each delivered event.
module tb_fleet_status_tracker;
  localparam int unsigned NB = 5;
  localparam int unsigned BC = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fleet_status_tracker_if #(.NUM_BOATS(NB), .BOAT_CELLS(BC)) bus ();

  fleet_status_tracker #(.NUM_BOATS(NB), .BOAT_CELLS(BC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit ack_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One enable edge with rows r0..r4.
  task automatic apply(input logic [4:0] r0, r1, r2, r3, r4);
    bus.barcos[0] = r0;
    bus.barcos[1] = r1;
    bus.barcos[2] = r2;
    bus.barcos[3] = r3;
    bus.barcos[4] = r4;
    bus.enable = 1'b1;
    @(posedge clk);
    #2 bus.enable = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: accept every presented event and compare against the scoreboard.
  initial begin
    bus.evt_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && bus.evt_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL evt_unexpected: got id %0d expected none", bus.evt_id);
        end else begin
          chk("evt_id", 32'(bus.evt_id), 32'(exp_q.pop_front()));
        end
        bus.evt_ack = 1'b1;
      end else begin
        bus.evt_ack = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clear = 1'b0;
    for (int j = 0; j < NB; j++) bus.barcos[j] = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_alive", 32'(bus.alive), 0);
    chk("rst_sunk", 32'(bus.sunk_count), 0);
    chk("rst_all_sunk", 32'(bus.all_sunk), 0);
    chk("rst_evt_valid", 32'(bus.evt_valid), 0);
    chk("rst_armed", 32'(bus.armed), 0);

    // Baseline sample.
    apply(5'h1F, 5'h07, 5'h01, 5'h03, 5'h10);
    @(negedge clk);
    chk("base_alive", 32'(bus.alive), 32'b11111);
    chk("base_armed", 32'(bus.armed), 1);
    chk("base_evt_valid", 32'(bus.evt_valid), 0);
    chk("base_sunk", 32'(bus.sunk_count), 0);

    // Single sink of boat 2.
    exp_q.push_back(2);
    apply(5'h1F, 5'h07, 5'h00, 5'h03, 5'h10);
    @(negedge clk);
    chk("s1_alive", 32'(bus.alive), 32'b11011);
    chk("s1_sunk", 32'(bus.sunk_count), 1);
    chk("s1_evt_valid", 32'(bus.evt_valid), 1);
    wait_neg(1);
    chk("s1_drained", 32'(bus.evt_valid), 0);

    // Boats 0 and 4 in one sample: delivered 0 then 4.
    exp_q.push_back(0);
    exp_q.push_back(4);
    apply(5'h00, 5'h07, 5'h00, 5'h03, 5'h00);
    @(negedge clk);
    chk("s2_alive", 32'(bus.alive), 32'b01010);
    chk("s2_sunk", 32'(bus.sunk_count), 3);
    chk("s2_evt_valid", 32'(bus.evt_valid), 1);
    wait_neg(2);
    chk("s2_drained", 32'(bus.evt_valid), 0);

    // Boat 1 sinks, then its row comes back non-zero.
    exp_q.push_back(1);
    apply(5'h00, 5'h00, 5'h00, 5'h03, 5'h00);
    @(negedge clk);
    chk("s3_alive", 32'(bus.alive), 32'b01000);
    chk("s3_sunk", 32'(bus.sunk_count), 4);
    wait_neg(1);
    apply(5'h00, 5'h02, 5'h00, 5'h03, 5'h00);
    @(negedge clk);
`ifdef FLEET_STICKY_SUNK_EN
    chk("refloat_alive", 32'(bus.alive), 32'b01000);
    chk("refloat_evt_valid", 32'(bus.evt_valid), 0);
`else
    chk("refloat_alive", 32'(bus.alive), 32'b01010);
    chk("refloat_sunk", 32'(bus.sunk_count), 3);
    exp_q.push_back(1);
    apply(5'h00, 5'h00, 5'h00, 5'h03, 5'h00);
    @(negedge clk);
    chk("resink_alive", 32'(bus.alive), 32'b01000);
    chk("resink_evt_valid", 32'(bus.evt_valid), 1);
    wait_neg(1);
`endif

    // Last boat sinks: game over, then later samples are ignored.
    exp_q.push_back(3);
    apply(5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    @(negedge clk);
    chk("over_all_sunk", 32'(bus.all_sunk), 1);
    chk("over_sunk", 32'(bus.sunk_count), 5);
    chk("over_armed", 32'(bus.armed), 1);
    wait_neg(1);
    chk("over_drained", 32'(bus.evt_valid), 0);
    apply(5'h1F, 5'h07, 5'h01, 5'h03, 5'h10);
    @(negedge clk);
    chk("over_hold_alive", 32'(bus.alive), 0);
    chk("over_hold_all_sunk", 32'(bus.all_sunk), 1);

    // New game via clear, then clear mid-game with two events pending.
    bus.clear = 1'b1;
    @(posedge clk);
    #2 bus.clear = 1'b0;
    @(negedge clk);
    chk("clr1_armed", 32'(bus.armed), 0);
    chk("clr1_all_sunk", 32'(bus.all_sunk), 0);
    apply(5'h1F, 5'h07, 5'h01, 5'h03, 5'h10);
    ack_en = 1'b0;
    apply(5'h00, 5'h07, 5'h00, 5'h03, 5'h10);
    @(negedge clk);
    chk("pend_evt_valid", 32'(bus.evt_valid), 1);
    chk("pend_evt_id", 32'(bus.evt_id), 0);
    bus.clear = 1'b1;
    bus.enable = 1'b1;
    @(posedge clk);
    #2 bus.clear = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("clr2_evt_valid", 32'(bus.evt_valid), 0);
    chk("clr2_armed", 32'(bus.armed), 0);
    chk("clr2_alive", 32'(bus.alive), 0);
    chk("clr2_sunk", 32'(bus.sunk_count), 0);
    ack_en = 1'b1;

    // All-zero baseline goes straight to OVER with no events.
    apply(5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    @(negedge clk);
    chk("zbase_all_sunk", 32'(bus.all_sunk), 1);
    chk("zbase_sunk", 32'(bus.sunk_count), 5);
    chk("zbase_evt_valid", 32'(bus.evt_valid), 0);

    // Reset from OVER.
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst2_all_sunk", 32'(bus.all_sunk), 0);
    chk("rst2_armed", 32'(bus.armed), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
